// File: rtl/cache_arb_pkg.sv
// Shared types for the cache port arbiter: requester IDs and cache op codes.
package cache_arb_pkg;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;

    localparam logic CACHE_READ  = 1'b0;
    localparam logic CACHE_WRITE = 1'b1;

endpackage

// File: rtl/cache_port_arbiter_tag_fifo.sv
// In-order FIFO of requester IDs for outstanding cache requests.
module arb_tag_fifo
    import cache_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  req_id_t push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output req_id_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    req_id_t         mem_q [DEPTH];
    req_id_t         mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Pointers are PW bits wide so they wrap modulo DEPTH on their own.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= REQ_IF;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache port between IF and MEM requesters and routes responses.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin ties (default: MEM wins).
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_resp_valid,
    input  logic              if_resp_ready,
    output logic [DATA_W-1:0] if_resp_data,
    input  logic              mem_req_valid,
    output logic              mem_req_ready,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_op,
    input  logic [DATA_W-1:0] mem_req_write_data,
    output logic              mem_resp_valid,
    input  logic              mem_resp_ready,
    output logic [DATA_W-1:0] mem_resp_data,
    output logic              cache_valid_in,
    input  logic              cache_ready_in,
    output logic [ADDR_W-1:0] cache_addr_in,
    output logic              cache_op_in,
    output logic [DATA_W-1:0] cache_write_data_in,
    input  logic              cache_valid_out,
    output logic              cache_ready_out,
    input  logic [DATA_W-1:0] cache_data_out,
    output logic              err
);

    logic    full, empty;
    req_id_t head;
    logic    gnt_vld, is_mem, head_mem;
    req_id_t gnt_id;
    logic    accept, pop;
    logic    lock_q, lock_d;
    req_id_t lock_id_q, lock_id_d;
    logic    err_q, err_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    req_id_t last_grant_q, last_grant_d;
`endif

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = REQ_IF;
        if (!full) begin
            if (lock_q) begin
                gnt_vld = 1'b1;
                gnt_id  = lock_id_q;
            end else if (if_req_valid && mem_req_valid) begin
                gnt_vld = 1'b1;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                gnt_id  = (last_grant_q == REQ_IF) ? REQ_MEM : REQ_IF;
`else
                gnt_id  = REQ_MEM;
`endif
            end else if (mem_req_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = REQ_MEM;
            end else if (if_req_valid) begin
                gnt_vld = 1'b1;
                gnt_id  = REQ_IF;
            end
        end
    end

    assign is_mem = (gnt_id == REQ_MEM);

    // Gating with reset keeps every handshake output low while reset is held.
    assign cache_valid_in      = reset & gnt_vld;
    assign cache_addr_in       = is_mem ? mem_req_addr : if_req_addr;
    assign cache_op_in         = is_mem ? mem_req_op : CACHE_READ;
    assign cache_write_data_in = is_mem ? mem_req_write_data : '0;

    assign if_req_ready  = cache_valid_in & cache_ready_in & ~is_mem;
    assign mem_req_ready = cache_valid_in & cache_ready_in & is_mem;
    assign accept        = cache_valid_in & cache_ready_in;

    assign head_mem        = (head == REQ_MEM);
    assign cache_ready_out = reset &
        (empty | (head_mem ? mem_resp_ready : if_resp_ready));
    assign if_resp_valid   = reset & cache_valid_out & ~empty & ~head_mem;
    assign mem_resp_valid  = reset & cache_valid_out & ~empty & head_mem;
    assign if_resp_data    = cache_data_out;
    assign mem_resp_data   = cache_data_out;
    assign pop             = cache_valid_out & cache_ready_out & ~empty;
    assign err             = err_q;

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (cache_valid_in) begin
            lock_d    = ~cache_ready_in;
            lock_id_d = gnt_id;
        end
        err_d = err_q | (cache_valid_out & empty);
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        last_grant_d = accept ? gnt_id : last_grant_q;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q       <= 1'b0;
            lock_id_q    <= REQ_IF;
            err_q        <= 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_grant_q <= REQ_IF;
`endif
        end else begin
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            err_q        <= err_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    arb_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (accept),
        .push_id (gnt_id),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed plus random bench for cache_port_arbiter against a queue-based model.
module tb_cache_port_arbiter;
    import cache_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req_valid, if_req_ready;
    logic [AW-1:0] if_req_addr;
    logic          if_resp_valid, if_resp_ready;
    logic [DW-1:0] if_resp_data;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_op;
    logic [DW-1:0] mem_req_write_data;
    logic          mem_resp_valid, mem_resp_ready;
    logic [DW-1:0] mem_resp_data;
    logic          cache_valid_in, cache_ready_in;
    logic [AW-1:0] cache_addr_in;
    logic          cache_op_in;
    logic [DW-1:0] cache_write_data_in;
    logic          cache_valid_out, cache_ready_out;
    logic [DW-1:0] cache_data_out;
    logic          err;

    cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
        .clk                 (clk),
        .reset               (reset),
        .if_req_valid        (if_req_valid),
        .if_req_ready        (if_req_ready),
        .if_req_addr         (if_req_addr),
        .if_resp_valid       (if_resp_valid),
        .if_resp_ready       (if_resp_ready),
        .if_resp_data        (if_resp_data),
        .mem_req_valid       (mem_req_valid),
        .mem_req_ready       (mem_req_ready),
        .mem_req_addr        (mem_req_addr),
        .mem_req_op          (mem_req_op),
        .mem_req_write_data  (mem_req_write_data),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_ready      (mem_resp_ready),
        .mem_resp_data       (mem_resp_data),
        .cache_valid_in      (cache_valid_in),
        .cache_ready_in      (cache_ready_in),
        .cache_addr_in       (cache_addr_in),
        .cache_op_in         (cache_op_in),
        .cache_write_data_in (cache_write_data_in),
        .cache_valid_out     (cache_valid_out),
        .cache_ready_out     (cache_ready_out),
        .cache_data_out      (cache_data_out),
        .err                 (err)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: outstanding IDs in issue order (0 = IF, 1 = MEM).
    int q[$];
    bit held;
    int held_id;
    int last_g;
    bit err_m;
    bit e_ifr, e_memr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        held   = 1'b0;
        held_id = 0;
        last_g = 0;
        err_m  = 1'b0;
    endtask

    task automatic tick();
        bit full, empty, cv, cro;
        int g, head;
        #2;
        full  = (q.size() == D);
        empty = (q.size() == 0);
        head  = empty ? -1 : q[0];
        g = -1;
        if (!full) begin
            if (held) g = held_id;
            else if (if_req_valid && mem_req_valid) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                g = (last_g == 1) ? 0 : 1;
`else
                g = 1;
`endif
            end
            else if (mem_req_valid) g = 1;
            else if (if_req_valid) g = 0;
        end
        cv = reset && (g >= 0);
        chk("cache_valid_in", 32'(cache_valid_in), 32'(cv));
        if (cv) begin
            chk("cache_addr_in", cache_addr_in,
                (g == 1) ? mem_req_addr : if_req_addr);
            chk("cache_op_in", 32'(cache_op_in),
                (g == 1) ? 32'(mem_req_op) : 32'(0));
            chk("cache_write_data_in", cache_write_data_in,
                (g == 1) ? mem_req_write_data : 32'h0);
        end
        e_ifr  = cv && cache_ready_in && (g == 0);
        e_memr = cv && cache_ready_in && (g == 1);
        chk("if_req_ready", 32'(if_req_ready), 32'(e_ifr));
        chk("mem_req_ready", 32'(mem_req_ready), 32'(e_memr));
        if (!reset) cro = 1'b0;
        else if (empty) cro = 1'b1;
        else cro = (head == 1) ? mem_resp_ready : if_resp_ready;
        chk("cache_ready_out", 32'(cache_ready_out), 32'(cro));
        chk("if_resp_valid", 32'(if_resp_valid),
            32'(reset && cache_valid_out && head == 0));
        chk("mem_resp_valid", 32'(mem_resp_valid),
            32'(reset && cache_valid_out && head == 1));
        if (if_resp_valid) chk("if_resp_data", if_resp_data, cache_data_out);
        if (mem_resp_valid) chk("mem_resp_data", mem_resp_data, cache_data_out);
        chk("err", 32'(err), 32'(err_m));
        if (reset) begin
            if (cache_valid_out && empty) err_m = 1'b1;
            if (cache_valid_out && cro && !empty) void'(q.pop_front());
            if (cv && cache_ready_in) begin
                q.push_back(g);
                held   = 1'b0;
                last_g = g;
            end else if (cv) begin
                held    = 1'b1;
                held_id = g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_valid       = 1'b0;
        if_req_addr        = '0;
        if_resp_ready      = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_addr       = '0;
        mem_req_op         = 1'b0;
        mem_req_write_data = '0;
        mem_resp_ready     = 1'b0;
        cache_ready_in     = 1'b0;
        cache_valid_out    = 1'b0;
        cache_data_out     = '0;
    endtask

    task automatic drain();
        if_req_valid    = 1'b0;
        mem_req_valid   = 1'b0;
        if_resp_ready   = 1'b1;
        mem_resp_ready  = 1'b1;
        for (int i = 0; i < 2 * D && q.size() > 0; i++) begin
            cache_valid_out = 1'b1;
            cache_data_out  = $urandom;
            tick();
        end
        cache_valid_out = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bit ifp, memp;
        idle_inputs();
        model_clear();
        reset = 1'b0;
        @(posedge clk);
        #1;
        // Outputs must stay quiet during reset even with a request present.
        if_req_valid   = 1'b1;
        cache_ready_in = 1'b1;
        tick();
        reset = 1'b1;
        idle_inputs();
        tick();

        // IF read of 0x100 answered with 0xDEAD.
        if_req_valid   = 1'b1;
        if_req_addr    = 32'h100;
        cache_ready_in = 1'b1;
        #1 chk("if_addr_fwd", cache_addr_in, 32'h100);
        tick();
        if_req_valid    = 1'b0;
        cache_valid_out = 1'b1;
        cache_data_out  = 32'hDEAD;
        if_resp_ready   = 1'b1;
        mem_resp_ready  = 1'b1;
        #1 chk("if_resp_dead", if_resp_data, 32'hDEAD);
        chk("mem_resp_quiet", 32'(mem_resp_valid), 32'(0));
        tick();
        cache_valid_out = 1'b0;

        // Tie for four cycles.
        for (int i = 0; i < 4; i++) begin
            if_req_valid  = 1'b1;
            if_req_addr   = 32'h200;
            mem_req_valid = 1'b1;
            mem_req_addr  = 32'h300;
            mem_req_op    = CACHE_READ;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            #1 chk("tie_grant_mem", 32'(mem_req_ready), 32'((i % 2) == 0));
`else
            #1 chk("tie_grant_mem", 32'(mem_req_ready), 32'(1));
`endif
            tick();
        end
        drain();

        // MEM write stalled three cycles with IF waiting.
        if_req_valid       = 1'b1;
        if_req_addr        = 32'h204;
        mem_req_valid      = 1'b1;
        mem_req_addr       = 32'h40;
        mem_req_op         = CACHE_WRITE;
        mem_req_write_data = 32'hCAFE;
        cache_ready_in     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("lock_addr", cache_addr_in, 32'h40);
            chk("lock_op", 32'(cache_op_in), 32'(1));
            tick();
        end
        cache_ready_in = 1'b1;
        #1 chk("lock_accept", 32'(mem_req_ready), 32'(1));
        tick();
        mem_req_valid = 1'b0;
        #1 chk("if_after_lock", 32'(if_req_ready), 32'(1));
        tick();
        drain();

        // Fill the tag FIFO, then free one slot.
        if_req_valid   = 1'b1;
        cache_ready_in = 1'b1;
        for (int i = 0; i < D; i++) begin
            if_req_addr = 32'h1000 + 32'(i * 4);
            tick();
        end
        if_req_addr = 32'h2000;
        #1 chk("full_stall", 32'(if_req_ready), 32'(0));
        tick();
        cache_valid_out = 1'b1;
        cache_data_out  = 32'h11;
        if_resp_ready   = 1'b1;
        #1 chk("full_no_bypass", 32'(if_req_ready), 32'(0));
        tick();
        cache_valid_out = 1'b0;
        #1 chk("full_freed", 32'(if_req_ready), 32'(1));
        tick();
        drain();

        // Interleaved IF, MEM, IF with MEM response back-pressured.
        cache_ready_in = 1'b1;
        if_req_valid   = 1'b1;
        if_req_addr    = 32'h500;
        tick();
        if_req_valid  = 1'b0;
        mem_req_valid = 1'b1;
        mem_req_addr  = 32'h600;
        mem_req_op    = CACHE_READ;
        tick();
        mem_req_valid = 1'b0;
        if_req_valid  = 1'b1;
        if_req_addr   = 32'h504;
        tick();
        if_req_valid    = 1'b0;
        cache_valid_out = 1'b1;
        cache_data_out  = 32'h1;
        if_resp_ready   = 1'b1;
        mem_resp_ready  = 1'b0;
        tick();
        cache_data_out = 32'h2;
        for (int i = 0; i < 2; i++) begin
            #1 chk("mem_held_valid", 32'(mem_resp_valid), 32'(1));
            chk("mem_held_ready", 32'(cache_ready_out), 32'(0));
            chk("if_not_early", 32'(if_resp_valid), 32'(0));
            tick();
        end
        mem_resp_ready = 1'b1;
        tick();
        cache_data_out = 32'h3;
        #1 chk("third_to_if", 32'(if_resp_valid), 32'(1));
        tick();
        cache_valid_out = 1'b0;

        // Stray response with nothing outstanding, then reset mid-stream.
        cache_valid_out = 1'b1;
        cache_data_out  = 32'hBAD;
        #1 chk("stray_drain", 32'(cache_ready_out), 32'(1));
        tick();
        cache_valid_out = 1'b0;
        #1 chk("err_set", 32'(err), 32'(1));
        if_req_valid   = 1'b1;
        if_req_addr    = 32'h700;
        cache_ready_in = 1'b1;
        tick();
        if_req_addr    = 32'h704;
        cache_ready_in = 1'b0;
        tick();
        reset = 1'b0;
        #1 chk("rst_err", 32'(err), 32'(0));
        chk("rst_valid", 32'(cache_valid_in), 32'(0));
        model_clear();
        tick();
        reset          = 1'b1;
        if_req_valid   = 1'b0;
        mem_req_valid  = 1'b1;
        mem_req_addr   = 32'h800;
        cache_ready_in = 1'b1;
        #1 chk("rst_lock_clear", 32'(mem_req_ready), 32'(1));
        tick();
        mem_req_valid = 1'b0;
        drain();

        // Random traffic obeying the hold-until-ready rule.
        idle_inputs();
        ifp  = 1'b0;
        memp = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!ifp && ($urandom_range(0, 1) == 1)) begin
                ifp         = 1'b1;
                if_req_addr = $urandom;
            end
            if (!memp && ($urandom_range(0, 1) == 1)) begin
                memp               = 1'b1;
                mem_req_addr       = $urandom;
                mem_req_op         = 1'($urandom_range(0, 1));
                mem_req_write_data = $urandom;
            end
            if_req_valid    = ifp;
            mem_req_valid   = memp;
            cache_ready_in  = ($urandom_range(0, 3) != 0);
            cache_valid_out = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            cache_data_out  = $urandom;
            if_resp_ready   = ($urandom_range(0, 3) != 0);
            mem_resp_ready  = ($urandom_range(0, 3) != 0);
            tick();
            if (e_ifr) ifp = 1'b0;
            if (e_memr) memp = 1'b0;
        end
        // Finish any request the arbiter already presented before draining.
        if_req_valid    = ifp;
        mem_req_valid   = memp;
        cache_valid_out = 1'b0;
        cache_ready_in  = 1'b1;
        for (int i = 0; i < 4 && held; i++) begin
            if (q.size() == D) begin
                cache_valid_out = 1'b1;
                if_resp_ready   = 1'b1;
                mem_resp_ready  = 1'b1;
            end else begin
                cache_valid_out = 1'b0;
            end
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Shares one cache port between instruction fetch (IF) and data load/store (MEM) requesters in the pipelined CPU. It arbitrates requests with a ready/valid handshake and forwards the winner combinationally to the cache. It records the winner's ID in an in-order tag FIFO and steers each cache response back to the requester that issued it. The block sits between the s1/sb3 stage logic and the single `cache` instance.

## Interface
- `ADDR_W`, 32, request address width
- `DATA_W`, 32, read/write data width
- `DEPTH`, 4, maximum outstanding requests (tag FIFO depth, power of 2, ≥2)

Ports:
- `clk`  in  1  sole clock
- `reset`  in  1  asynchronous, active-low reset
- `if_req_valid` in 1 / `if_req_ready` out 1 / `if_req_addr` in ADDR_W: IF read request
- `if_resp_valid` out 1 / `if_resp_ready` in 1 / `if_resp_data` out DATA_W: IF response
- `mem_req_valid` in 1 / `mem_req_ready` out 1 / `mem_req_addr` in ADDR_W: MEM request
- `mem_req_op` in 1 / `mem_req_write_data` in DATA_W: MEM request (0 read, 1 write)
- `mem_resp_valid` out 1 / `mem_resp_ready` in 1 / `mem_resp_data` out DATA_W: MEM response; writes get an ack beat
- `cache_valid_in` out 1 / `cache_ready_in` in 1 / `cache_addr_in` out ADDR_W / `cache_op_in` out 1 / `cache_write_data_in` out DATA_W: cache request
- `cache_valid_out` in 1 / `cache_ready_out` out 1 / `cache_data_out` in DATA_W: cache response
- `err` out 1: sticky flag, set when the cache returns a response with no outstanding tag

## Operation
- Request accepted: `cache_valid_in & cache_ready_in`. On acceptance, the granted ID is pushed to the tag FIFO.
- Grant eligibility:
  - No grant while FIFO is full (`count == DEPTH`). Then `cache_valid_in = 0` and both `*_req_ready = 0`.
  - Full is taken from the registered count; there is no same-cycle pop bypass.
- Request forwarding:
  - Granted requester's addr/op/data drive the cache directly.
  - IF always forces `cache_op_in = 0` and `cache_write_data_in = 0`.
- `*_req_ready = cache_ready_in & granted & ~full`; the non-granted requester sees ready 0.
- Grant lock:
  - If a grant is presented (`cache_valid_in = 1`) and not accepted, a `lock` register holds that grant next cycle regardless of the other requester.
  - `lock` clears on acceptance.
  - Requesters must hold valid and payload stable until ready.
- Arbitration with both requesters valid and unlocked: see Configuration.
- Response routing:
  - FIFO head selects the target. `*_resp_valid = cache_valid_out & ~empty & (head == ID)`.
  - `cache_ready_out` = the target's `resp_ready`. The other requester sees resp_valid 0.
  - Both `resp_data` outputs carry `cache_data_out`.
  - Pop occurs on the `cache_valid_out & cache_ready_out` handshake.
- Empty-FIFO response: `cache_ready_out = 1` (drain), beat discarded, `err <= 1`. `err` clears only on reset.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.

## Timing
- Request path is combinational: 0 cycles from requester to cache.
- Tag push and lock update are registered at the accepting/stalling edge.
- Response path is combinational: 0 cycles from cache to requester.
- Pop takes effect the next cycle.
- Back-to-back acceptance every cycle is supported until count reaches DEPTH.
- Reset (asynchronous assert, any time including mid-transfer):
  - count = 0, pointers = 0, lock = 0, err = 0, last_grant = IF.
  - All valid/ready outputs = 0 while reset is asserted.
  - In-flight tags are lost. The cache is required to be reset in the same cycle.

## Configuration
- `CACHE_ARB_ROUND_ROBIN_EN` defined:
  - On a tie, grant the requester that was not `last_grant`.
  - `last_grant` updates on every acceptance.
- Undefined: fixed priority, MEM beats IF on a tie; `last_grant` is unused.

## Structure
- Package `cache_arb_pkg` holds:
  - `req_id_t` (1 bit): `REQ_IF = 0`, `REQ_MEM = 1`.
  - `CACHE_READ = 1'b0`, `CACHE_WRITE = 1'b1` (shared with the cache and CPU).
- Sub-module `arb_tag_fifo`: DEPTH × `req_id_t`, with push/pop/full/empty/head.
- Arbitration, lock and steering logic stay in the top module.

## Test plan
- IF reads 0x100, no MEM traffic, cache returns 0xDEAD in 1 cycle:
  - `cache_addr_in = 0x100` the same cycle.
  - `if_resp_data = 0xDEAD`; `mem_resp_valid` stays 0.
- Both request in the same cycle, `cache_ready_in = 1`, for 4 cycles:
  - With the macro: grants alternate MEM, IF, MEM, IF.
  - Without it: MEM every cycle and IF starved.
- MEM write to 0x40 with `cache_ready_in = 0` for 3 cycles while IF is valid:
  - MEM stays granted and stable throughout (lock).
  - Accepted in cycle 4; then IF is granted.
- Issue 4 requests with no responses:
  - 5th request sees ready 0.
  - After one response pops the FIFO, the 5th is accepted the next cycle.
- Interleaved IF, MEM, IF issue with `mem_resp_ready` low for 2 cycles:
  - 2nd response is held.
  - 3rd response is not delivered to IF before the MEM beat.
- `cache_valid_out = 1` with an empty FIFO:
  - Beat is dropped and `err` goes 1.
  - Asserting `reset` low mid-stream clears `err` and count to 0.
